// File: rtl/run_key_debounce_pkg.sv
// run_key_debounce shared types: FSM state encoding and default timing constants.
// Imported by the debouncer top and its interface users.
package run_key_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_e;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned SYNC_STAGES_DEF     = 2;

endpackage

// File: rtl/run_key_debounce_if.sv
// Conditioned run-key outputs toward the run PIO.
// master: debouncer drives run_level, run_pulse, press_count; slave: consumer.
interface run_key_if;

   logic       run_level;
   logic       run_pulse;
   logic [7:0] press_count;

   modport master (
      output run_level,
      output run_pulse,
      output press_count
   );

   modport slave (
      input run_level,
      input run_pulse,
      input press_count
   );

endinterface

// File: rtl/run_key_debounce_sync.sv
// sync_ff: STAGES-deep synchronizer chain, synchronous active-high reset to 0.
// Ports: clk, reset, d_i (async input), q_o (synchronized output).
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/run_key_debounce.sv
// run_key_debounce: synchronizes and debounces the active-low run key.
// Ports: clk, reset (sync, active-high), key_n (raw pin), run_o (level/pulse/count).
module run_key_debounce
   import run_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_n,
   run_key_if.master  run_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             key_s;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [7:0]       count_q, count_d;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (~key_n),
      .q_o   (key_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RELEASED: begin
            if (key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!key_s) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (key_s) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered off the next state so they change on the
   // same edge the FSM enters PRESSED / leaves RELEASE_WAIT.
   always_comb begin
      level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      // Only a qualified press strobes; a rejected release bounce
      // (RELEASE_WAIT -> PRESSED) must not.
      pulse_d = (state_q == PRESS_WAIT) && (state_d == PRESSED);
      count_d = pulse_d ? count_q + 8'd1 : count_q;
   end

   assign run_o.run_level   = level_q;
   assign run_o.run_pulse   = pulse_q;
   assign run_o.press_count = count_q;

endmodule

// File: doc/run_key_debounce.md
# run_key_debounce

Conditions the raw, active-low push button that starts the game/render loop, producing the clean `run` level that the 1-bit `run` PIO samples as its `in_port`. Provides a metastability synchronizer, a counter-based debounce state machine, a single-cycle press strobe, and a wrapping press counter for diagnostics. Sits between the board key pin and the Platform Designer `run` input peripheral, in the same clock domain as that peripheral.

## Interface
- `DEBOUNCE_CYCLES`, 500000, clocks the synchronized input must hold a new value before it is accepted (10 ms at 50 MHz); legal range 1..2^24-1.
- `SYNC_STAGES`, 2, synchronizer flops on the raw key; minimum 2.
- `clk`  in  1  system clock, same as the PIO's `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  1  raw asynchronous button, 0 = pressed.
- `run_level`  out  1  debounced press level, 1 = pressed; drives PIO `in_port`.
- `run_pulse`  out  1  one-cycle strobe on each accepted press.
- `press_count`  out  8  number of accepted presses, wraps modulo 256.

## Operation
- Synchronizer: `key_n` inverted then passed through `SYNC_STAGES` flops → `key_s` (1 = pressed). Flops reset to 0.
- Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`; never exceeds `DEBOUNCE_CYCLES-1`.
- FSM states and transitions (evaluated every clock):
  - `RELEASED`: `key_s`=1 → `PRESS_WAIT`, `cnt`←0; otherwise stay.
  - `PRESS_WAIT`: `key_s`=0 → `RELEASED` (glitch rejected, no pulse, no count). `key_s`=1 and `cnt`==`DEBOUNCE_CYCLES-1` → `PRESSED`. Else `cnt`←`cnt`+1.
  - `PRESSED`: `key_s`=0 → `RELEASE_WAIT`, `cnt`←0; otherwise stay.
  - `RELEASE_WAIT`: `key_s`=1 → `PRESSED` (bounce rejected). `key_s`=0 and `cnt`==`DEBOUNCE_CYCLES-1` → `RELEASED`. Else `cnt`←`cnt`+1.
- `run_level` registered: 1 in `PRESSED` and `RELEASE_WAIT`, 0 otherwise.
- `run_pulse` registered: 1 for exactly the first cycle the FSM is in `PRESSED` arriving from `PRESS_WAIT`; never on `RELEASE_WAIT`→`PRESSED`.
- `press_count` increments in the same cycle `run_pulse` asserts; 255 + 1 → 0, no saturation.
- Held button: one pulse, one count, `run_level` stays 1 indefinitely.

## Timing
- Reset (synchronous, checked at `posedge clk`): state `RELEASED`, `cnt`=0, sync flops 0, `run_level`=0, `run_pulse`=0, `press_count`=0. Reset asserted mid-`PRESS_WAIT` or mid-`PRESSED` abandons the press: no pulse, no count; a button still held after reset must requalify through full synchronizer + debounce latency.
- Press latency: `key_s` rises at edge E → FSM enters `PRESS_WAIT` at E+1 → `PRESSED`, `run_level`=1, `run_pulse`=1 at E+`DEBOUNCE_CYCLES`+1. Raw pin to `run_level` = `SYNC_STAGES`+`DEBOUNCE_CYCLES`+1 clocks (+1 for sampling phase).
- Release latency identical with `run_level` falling; no strobe on release.
- `DEBOUNCE_CYCLES`=1: `PRESS_WAIT` lasts exactly one cycle.
- The downstream PIO adds one more register; software sees the level one clock after `run_level`.

## Structure
- Package `run_key_pkg`: FSM state enum (`RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`), default constants `DEBOUNCE_CYCLES_DEF`=500000, `SYNC_STAGES_DEF`=2.
- One sub-module `sync_ff` (parameterised depth, synchronous active-high reset to 0) for the synchronizer; FSM, counter and press counter in the top module.

## Test plan
(Bench overrides `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2.)
- Reset held 3 cycles with `key_n`=0 → all outputs 0; after release, `run_level` rises exactly 2+4+1 clocks after first sampling edge.
- Clean press: `key_n` 1→0 held 20 cycles → `run_pulse` high one cycle, `press_count`=1, `run_level`=1 until 7 clocks after release.
- Bounce: `key_n` low 3 cycles, high 1, low 10 → single pulse, `press_count`=1, `run_level` rise measured from the last low edge.
- Release bounce: while pressed, `key_n` high 2 cycles then low → `run_level` stays 1, no second pulse.
- Wrap: 256 clean presses → `press_count` back to 0, 256 pulses counted.
- Reset asserted in `PRESS_WAIT` → no pulse, `press_count` unchanged at 0.
